// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS sequence controller: FSM state encoding,
// phase codes reported to the host, and default sizing parameters.
package prbs_pkg;

   localparam int N_BYTES_DEF = 4;
   localparam int LEN_W_DEF   = 16;
   localparam int PAT_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_PATTERN = 3'd2,
      ST_RANDOM  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam logic [1:0] PH_IDLE    = 2'd0;
   localparam logic [1:0] PH_LOAD    = 2'd1;
   localparam logic [1:0] PH_PATTERN = 2'd2;
   localparam logic [1:0] PH_RANDOM  = 2'd3;

   // Map a controller state onto the externally visible phase code.
   function automatic logic [1:0] phase_of(input state_e s);
      logic [1:0] ph;
      case (s)
         ST_LOAD:    ph = PH_LOAD;
         ST_PATTERN: ph = PH_PATTERN;
         ST_RANDOM:  ph = PH_RANDOM;
         default:    ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/prbs_seq_cnt.sv
// Loadable down-counter shared by the LOAD, PATTERN and RANDOM phases.
// A load takes priority over a decrement; 'last' flags a count of one so the
// controller can leave a phase on the final cycle of that phase.
module prbs_seq_cnt
   import prbs_pkg::*;
#(
   parameter int W = LEN_W_DEF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: reload, decrement or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == W'(1));

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS sequence controller: loads N_BYTES seed bytes from the host, then
// times a seed-pattern phase and a random phase for the PRBS datapath.
// Optional macro PRBS_CTRL_ABORT_EN adds an 'abort' input that resets the
// datapath and returns to IDLE from any busy state without a done pulse.
// All outputs are registered and derived from the next state so they line
// up with the state register.
module prbs_seq_ctrl
   import prbs_pkg::*;
#(
   parameter int N_BYTES = N_BYTES_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
`ifdef PRBS_CTRL_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [7:0]       n_pattern_cfg,
   input  logic [LEN_W-1:0] prbs_len,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [7:0]       prbs_in,
   output logic             prbs_load,
   output logic [7:0]       prbs_n_pattern,
   output logic             prbs_rst,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       phase
);

   localparam int CNT_W = (LEN_W > PAT_W) ? LEN_W : PAT_W;

   state_e           state_q, state_d;
   logic [7:0]       n_pat_q, n_pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       prbs_in_q, prbs_in_d;
   logic             byte_ready_q, byte_ready_d;
   logic             prbs_load_q, prbs_load_d;
   logic             prbs_rst_q, prbs_rst_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       phase_q, phase_d;

   logic             cnt_load_s;
   logic             cnt_dec_s;
   logic [CNT_W-1:0] cnt_val_s;
   logic             cnt_last_s;
   logic             hs_s;
   logic             abort_s;
   logic             abort_hit_s;
   logic [PAT_W-1:0] pat_cycles_s;

`ifdef PRBS_CTRL_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   assign pat_cycles_s = PAT_W'(n_pat_q) * PAT_W'(N_BYTES);

   prbs_seq_cnt #(.W(CNT_W)) u_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (cnt_load_s),
      .load_val (cnt_val_s),
      .dec      (cnt_dec_s),
      .last     (cnt_last_s)
   );

   // Next-state, counter control and registered-output next values.
   always_comb begin
      state_d     = state_q;
      n_pat_d     = n_pat_q;
      len_d       = len_q;
      prbs_in_d   = prbs_in_q;
      cnt_load_s  = 1'b0;
      cnt_dec_s   = 1'b0;
      cnt_val_s   = {CNT_W{1'b0}};
      hs_s        = (state_q == ST_LOAD) && byte_ready_q && byte_valid;
      abort_hit_s = abort_s && (state_q != ST_IDLE);

      if (abort_hit_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_LOAD;
                  n_pat_d    = n_pattern_cfg;
                  len_d      = prbs_len;
                  cnt_load_s = 1'b1;
                  cnt_val_s  = CNT_W'(N_BYTES);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (hs_s) begin
                  prbs_in_d = byte_in;
                  if (cnt_last_s) begin
                     cnt_load_s = 1'b1;
                     if (n_pat_q != 8'd0) begin
                        state_d   = ST_PATTERN;
                        cnt_val_s = CNT_W'(pat_cycles_s);
                     end else if (len_q != {LEN_W{1'b0}}) begin
                        state_d   = ST_RANDOM;
                        cnt_val_s = CNT_W'(len_q);
                     end else begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     cnt_dec_s = 1'b1;
                  end
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_PATTERN: begin
               if (cnt_last_s) begin
                  if (len_q != {LEN_W{1'b0}}) begin
                     state_d    = ST_RANDOM;
                     cnt_load_s = 1'b1;
                     cnt_val_s  = CNT_W'(len_q);
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_RANDOM: begin
               if (cnt_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_dec_s = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // The first LOAD cycle (entry from IDLE) resets the datapath and keeps
      // byte_ready low; an abort also resets the datapath for one cycle.
      prbs_load_d  = hs_s && !abort_hit_s;
      byte_ready_d = (state_d == ST_LOAD) && (state_q == ST_LOAD);
      prbs_rst_d   = !(abort_hit_s || ((state_q == ST_IDLE) && (state_d == ST_LOAD)));
      out_valid_d  = (state_d == ST_PATTERN) || (state_d == ST_RANDOM);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      phase_d      = phase_of(state_d);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         n_pat_q      <= 8'd0;
         len_q        <= {LEN_W{1'b0}};
         prbs_in_q    <= 8'd0;
         byte_ready_q <= 1'b0;
         prbs_load_q  <= 1'b0;
         prbs_rst_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         phase_q      <= PH_IDLE;
      end else begin
         state_q      <= state_d;
         n_pat_q      <= n_pat_d;
         len_q        <= len_d;
         prbs_in_q    <= prbs_in_d;
         byte_ready_q <= byte_ready_d;
         prbs_load_q  <= prbs_load_d;
         prbs_rst_q   <= prbs_rst_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         phase_q      <= phase_d;
      end
   end

   assign byte_ready     = byte_ready_q;
   assign prbs_in        = prbs_in_q;
   assign prbs_load      = prbs_load_q;
   assign prbs_n_pattern = n_pat_q;
   assign prbs_rst       = prbs_rst_q;
   assign out_valid      = out_valid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign phase          = phase_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed testbench for prbs_seq_ctrl. Per-cycle observations are gathered
// into run statistics, which are then compared with hand-computed values.
// Cycle numbering: the cycle observed right after the start edge is cycle 1.
module tb_prbs_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [7:0]  n_pattern_cfg;
   logic [15:0] prbs_len;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  prbs_in;
   logic        prbs_load;
   logic [7:0]  prbs_n_pattern;
   logic        prbs_rst;
   logic        out_valid;
   logic        busy;
   logic        done;
   logic [1:0]  phase;
`ifdef PRBS_CTRL_ABORT_EN
   logic        abort;
`endif

   int tests = 0;
   int fails = 0;

   int         cyc, n_load, n_valid, n_ph1, n_ph2, n_ph3, n_done, n_rst_low;
   int         done_cyc, last_valid, bad_ov, timeouts;
   logic       skip_seen;
   logic [1:0] prev_phase;
   logic [7:0] ld_bytes [4];

   always #5 CLK = ~CLK;

   prbs_seq_ctrl #(.N_BYTES(4), .LEN_W(16)) dut (
      .CLK            (CLK),
      .RST            (RST),
`ifdef PRBS_CTRL_ABORT_EN
      .abort          (abort),
`endif
      .start          (start),
      .n_pattern_cfg  (n_pattern_cfg),
      .prbs_len       (prbs_len),
      .byte_in        (byte_in),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .prbs_in        (prbs_in),
      .prbs_load      (prbs_load),
      .prbs_n_pattern (prbs_n_pattern),
      .prbs_rst       (prbs_rst),
      .out_valid      (out_valid),
      .busy           (busy),
      .done           (done),
      .phase          (phase)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      cyc = 0; n_load = 0; n_valid = 0; n_ph1 = 0; n_ph2 = 0; n_ph3 = 0;
      n_done = 0; n_rst_low = 0; done_cyc = 0; last_valid = 0; bad_ov = 0;
      timeouts = 0; skip_seen = 1'b0; prev_phase = 2'd0;
      for (int i = 0; i < 4; i++) ld_bytes[i] = 8'h00;
   endtask

   task automatic observe();
      cyc++;
      if (prbs_load) begin
         if (n_load < 4) ld_bytes[n_load] = prbs_in;
         n_load++;
      end
      if (out_valid) begin
         n_valid++;
         last_valid = cyc;
      end
      if (out_valid !== ((phase == 2'd2) || (phase == 2'd3))) bad_ov++;
      if (phase == 2'd1) n_ph1++;
      if (phase == 2'd2) n_ph2++;
      if (phase == 2'd3) n_ph3++;
      if (prev_phase == 2'd1 && phase == 2'd3) skip_seen = 1'b1;
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (!prbs_rst) n_rst_low++;
      prev_phase = phase;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      observe();
   endtask

   task automatic feed(input logic [31:0] bw, input int gap);
      int   k;
      logic hs;
      for (int i = 0; i < 4; i++) begin
         byte_valid = 1'b0;
         repeat (gap) step();
         byte_in    = bw[31-8*i -: 8];
         byte_valid = 1'b1;
         hs = 1'b0;
         k  = 0;
         while (!hs && k < 100) begin
            hs = byte_ready;
            step();
            k++;
         end
         if (!hs) timeouts++;
      end
      byte_valid = 1'b0;
   endtask

   // Step until done is seen, then one more cycle (expected IDLE).
   task automatic wait_done();
      int k;
      k = 0;
      while (n_done == 0 && k < 2000) begin
         step();
         k++;
      end
      if (n_done == 0) timeouts++;
      step();
   endtask

   task automatic begin_run(input logic [7:0] n, input logic [15:0] len, input logic hold);
      clear_obs();
      n_pattern_cfg = n;
      prbs_len      = len;
      start         = 1'b1;
      step();
      start         = hold;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_byte_ready"}, byte_ready, 0);
      check({tag, "_prbs_in"}, prbs_in, 0);
      check({tag, "_prbs_load"}, prbs_load, 0);
      check({tag, "_n_pattern"}, prbs_n_pattern, 0);
      check({tag, "_prbs_rst"}, prbs_rst, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_phase"}, phase, 0);
   endtask

   initial begin
      RST = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      n_pattern_cfg = 8'd0; prbs_len = 16'd0;
`ifdef PRBS_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      clear_obs();
      step(); step();
      check_reset("rst");
      RST = 1'b1;
      step();
      check("rst_release_prbs_rst", prbs_rst, 1);
      check("rst_release_busy", busy, 0);

      // Run 1: n=1, len=3, back-to-back bytes; config changed while busy.
      begin_run(8'd1, 16'd3, 1'b0);
      check("r1_load1_busy", busy, 1);
      check("r1_load1_phase", phase, 1);
      check("r1_load1_prbs_rst", prbs_rst, 0);
      check("r1_load1_byte_ready", byte_ready, 0);
      check("r1_n_pattern", prbs_n_pattern, 8'd1);
      n_pattern_cfg = 8'd7;
      prbs_len      = 16'd9;
      feed(32'h10ABCDEF, 0);
      check("r1_phase_after_load", phase, 2);
      check("r1_ready_after_load", byte_ready, 0);
      wait_done();
      check("r1_timeouts", timeouts, 0);
      check("r1_n_load", n_load, 4);
      check("r1_byte0", ld_bytes[0], 8'h10);
      check("r1_byte1", ld_bytes[1], 8'hAB);
      check("r1_byte2", ld_bytes[2], 8'hCD);
      check("r1_byte3", ld_bytes[3], 8'hEF);
      check("r1_n_ph1", n_ph1, 5);
      check("r1_n_ph2", n_ph2, 4);
      check("r1_n_ph3", n_ph3, 3);
      check("r1_n_valid", n_valid, 7);
      check("r1_last_valid", last_valid, 12);
      check("r1_done_cyc", done_cyc, 13);
      check("r1_n_done", n_done, 1);
      check("r1_n_rst_low", n_rst_low, 1);
      check("r1_bad_ov", bad_ov, 0);
      check("r1_n_pattern_held", prbs_n_pattern, 8'd1);
      check("r1_end_busy", busy, 0);
      check("r1_end_phase", phase, 0);

      // Run 2: n=0 skips PATTERN.
      begin_run(8'd0, 16'd5, 1'b0);
      feed(32'h01020304, 0);
      wait_done();
      check("r2_timeouts", timeouts, 0);
      check("r2_skip", skip_seen, 1);
      check("r2_n_ph2", n_ph2, 0);
      check("r2_n_valid", n_valid, 5);
      check("r2_done_cyc", done_cyc, 11);
      check("r2_n_done", n_done, 1);
      check("r2_byte3", ld_bytes[3], 8'h04);

      // Run 3: n=2, len=0, 3-cycle byte_valid gaps stall LOAD.
      begin_run(8'd2, 16'd0, 1'b0);
      feed(32'h5A5AA5C3, 3);
      wait_done();
      check("r3_timeouts", timeouts, 0);
      check("r3_n_ph1", n_ph1, 16);
      check("r3_n_load", n_load, 4);
      check("r3_byte3", ld_bytes[3], 8'hC3);
      check("r3_n_ph2", n_ph2, 8);
      check("r3_n_ph3", n_ph3, 0);
      check("r3_n_valid", n_valid, 8);
      check("r3_last_valid", last_valid, 24);
      check("r3_done_cyc", done_cyc, 25);
      check("r3_n_done", n_done, 1);

      // Run 4: reset asserted mid-PATTERN, then a complete new run.
      begin_run(8'd3, 16'd2, 1'b0);
      feed(32'h11223344, 0);
      step(); step();
      check("r4_in_pattern", phase, 2);
      RST = 1'b0;
      step();
      check_reset("r4_rst");
      RST = 1'b1;
      step();
      check("r4_release_prbs_rst", prbs_rst, 1);
      begin_run(8'd1, 16'd1, 1'b0);
      feed(32'h99887766, 0);
      wait_done();
      check("r4b_timeouts", timeouts, 0);
      check("r4b_n_ph1", n_ph1, 5);
      check("r4b_n_load", n_load, 4);
      check("r4b_byte0", ld_bytes[0], 8'h99);
      check("r4b_n_valid", n_valid, 5);
      check("r4b_done_cyc", done_cyc, 11);

      // Run 5: start held high for the whole run.
      begin_run(8'd1, 16'd2, 1'b1);
      feed(32'hDEADBEEF, 0);
      wait_done();
      check("r5_timeouts", timeouts, 0);
      check("r5_n_done", n_done, 1);
      check("r5_n_rst_low", n_rst_low, 1);
      check("r5_done_cyc", done_cyc, 12);
      check("r5_idle_busy", busy, 0);
      check("r5_idle_phase", phase, 0);
      step();
      check("r5_restart_phase", phase, 1);
      check("r5_restart_prbs_rst", prbs_rst, 0);
      start = 1'b0;
      RST   = 1'b0;
      step();
      RST   = 1'b1;
      step();

`ifdef PRBS_CTRL_ABORT_EN
      // Run 6: abort during RANDOM.
      begin_run(8'd0, 16'd10, 1'b0);
      feed(32'h0F1E2D3C, 0);
      step(); step();
      check("r6_in_random", phase, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("r6_abort_prbs_rst", prbs_rst, 0);
      check("r6_abort_busy", busy, 0);
      check("r6_abort_phase", phase, 0);
      check("r6_abort_out_valid", out_valid, 0);
      step();
      check("r6_after_prbs_rst", prbs_rst, 1);
      repeat (3) step();
      check("r6_n_done", n_done, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
